booth_ctrl: RTL and testbench

- Control FSM that sits directly upstream of the 16-bit Booth multiplier datapath and drives all of its load, clear, shift, add/sub and counter strobes.
- Accepts two operand beats over a valid/ready handshake: multiplicand first, then multiplier.
- Sequences the radix-2 Booth iterations from the datapath status inputs.
- Presents the finished product, held in the datapath A:Q registers, with a valid/ready output handshake.

---
 rtl/booth_ctrl_if.sv | 21 ++
 rtl/booth_ctrl.sv | 130 +++++++++++++
 tb/tb_booth_ctrl.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/booth_ctrl_if.sv
// Operand/product handshake bundle between a producer/consumer and booth_ctrl.
interface booth_ctrl_if #(
  parameter int unsigned WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic             busy;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, busy
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, busy
  );
endinterface

// File: rtl/booth_ctrl.sv
// Radix-2 Booth multiplier controller: takes multiplicand then multiplier beats,
// sequences EVAL/SHIFT iterations on the datapath, and holds the A:Q product.
module booth_ctrl #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  booth_ctrl_if.slave      bus,
  output logic [WIDTH-1:0] data_out,
  input  logic             q0,
  input  logic             qm1,
  input  logic             eqz,
  output logic             ldA,
  output logic             ldQ,
  output logic             ldM,
  output logic             clrA,
  output logic             clrQ,
  output logic             clrff,
  output logic             sftA,
  output logic             sftQ,
  output logic             addsub,
  output logic             decr,
  output logic             ldCnt
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOADQ = 3'd1,
    EVAL  = 3'd2,
    SHIFT = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t state;
  state_t state_nxt;

  assign data_out = bus.in_data;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next state, handshake and datapath strobes
  always_comb begin
    state_nxt     = state;
    bus.in_ready  = 1'b0;
    bus.busy      = 1'b0;
    bus.out_valid = 1'b0;
    ldA    = 1'b0;
    ldQ    = 1'b0;
    ldM    = 1'b0;
    clrA   = 1'b0;
    clrQ   = 1'b0;
    clrff  = 1'b0;
    sftA   = 1'b0;
    sftQ   = 1'b0;
    addsub = 1'b0;
    decr   = 1'b0;
    ldCnt  = 1'b0;

    case (state)
      IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) begin
          ldM       = 1'b1;
          clrA      = 1'b1;
          clrQ      = 1'b1;
          clrff     = 1'b1;
          ldCnt     = 1'b1;
          state_nxt = LOADQ;
        end
      end
      LOADQ: begin
        bus.in_ready = 1'b1;
        bus.busy     = 1'b1;
        if (bus.in_valid) begin
          ldQ       = 1'b1;
          state_nxt = EVAL;
        end
      end
      EVAL: begin
        bus.busy = 1'b1;
        if (eqz) begin
          state_nxt = DONE;
        end else begin
          // Booth recoding: 01 adds M, 10 subtracts M
          case ({q0, qm1})
            2'b01: begin
              ldA    = 1'b1;
              addsub = 1'b1;
            end
            2'b10: ldA = 1'b1;
            default: ;
          endcase
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        bus.busy  = 1'b1;
        sftA      = 1'b1;
        sftQ      = 1'b1;
        decr      = 1'b1;
        state_nxt = EVAL;
      end
      DONE: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase

    // Strobes must not reach the datapath while reset is asserted
    if (rst) begin
      ldA    = 1'b0;
      ldQ    = 1'b0;
      ldM    = 1'b0;
      clrA   = 1'b0;
      clrQ   = 1'b0;
      clrff  = 1'b0;
      sftA   = 1'b0;
      sftQ   = 1'b0;
      addsub = 1'b0;
      decr   = 1'b0;
      ldCnt  = 1'b0;
    end
  end

endmodule

// File: tb/tb_booth_ctrl.sv
// Self-checking bench for booth_ctrl: a behavioural Booth datapath closes the loop,
// and a timeline model predicts handshakes, every strobe pattern and the product.
module tb_booth_ctrl;
  localparam int unsigned W = 16;
  localparam int unsigned LAT = 2 * W + 1;

  // Strobe bit order: {ldA,ldQ,ldM,clrA,clrQ,clrff,sftA,sftQ,addsub,decr,ldCnt}
  localparam logic [10:0] S_BEAT1 = 11'b001_1110_0001;
  localparam logic [10:0] S_BEAT2 = 11'b010_0000_0000;
  localparam logic [10:0] S_SHIFT = 11'b000_0001_1010;
  localparam logic [10:0] S_ADD   = 11'b100_0000_0100;
  localparam logic [10:0] S_SUB   = 11'b100_0000_0000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [W-1:0] data_out;
  logic q0, qm1, eqz;
  logic ldA, ldQ, ldM, clrA, clrQ, clrff, sftA, sftQ, addsub, decr, ldCnt;

  booth_ctrl_if #(.WIDTH(W)) bus ();

  booth_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .bus(bus), .data_out(data_out),
    .q0(q0), .qm1(qm1), .eqz(eqz),
    .ldA(ldA), .ldQ(ldQ), .ldM(ldM), .clrA(clrA), .clrQ(clrQ), .clrff(clrff),
    .sftA(sftA), .sftQ(sftQ), .addsub(addsub), .decr(decr), .ldCnt(ldCnt)
  );

  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural datapath; A carries one guard bit so that subtracting -2^(W-1) stays exact
  logic signed [W:0] dp_a   = '0;
  logic [W-1:0]      dp_q   = '0;
  logic              dp_qm1 = 1'b0;
  logic [W-1:0]      dp_m   = '0;
  int                dp_cnt = 0;

  assign q0  = dp_q[0];
  assign qm1 = dp_qm1;
  assign eqz = (dp_cnt == 0);

  always_ff @(posedge clk) begin
    if (ldM) dp_m <= data_out;
    if (clrA)      dp_a <= '0;
    else if (ldA)  dp_a <= addsub ? dp_a + {dp_m[W-1], dp_m} : dp_a - {dp_m[W-1], dp_m};
    else if (sftA) dp_a <= dp_a >>> 1;
    if (clrQ)      dp_q <= '0;
    else if (ldQ)  dp_q <= data_out;
    else if (sftQ) dp_q <= {dp_a[0], dp_q[W-1:1]};
    if (clrff)     dp_qm1 <= 1'b0;
    else if (sftQ) dp_qm1 <= dp_q[0];
    if (ldCnt)     dp_cnt <= W;
    else if (decr) dp_cnt <= dp_cnt - 1;
  end

  // Number of add/sub steps Booth recoding needs: bit changes scanning up from Q(-1)=0
  function automatic int booth_ops(input logic [W-1:0] q);
    int n = 0;
    logic prv = 1'b0;
    for (int i = 0; i < int'(W); i++) begin
      if (q[i] != prv) n++;
      prv = q[i];
    end
    return n;
  endfunction

  function automatic logic [31:0] smul(input logic [W-1:0] a, input logic [W-1:0] b);
    logic signed [31:0] sa, sb;
    sa = $signed({{(32-W){a[W-1]}}, a});
    sb = $signed({{(32-W){b[W-1]}}, b});
    return 32'(sa * sb);
  endfunction

  // Timeline model: 0 wait beat 1, 1 wait beat 2, 2 computing, 3 product held
  int          ph = 0;
  int          left = 0;
  logic [W-1:0] mdl_m = '0, mdl_q = '0;
  int          n_lda = 0, n_sft = 0, n_dec = 0;
  bit          seen_done = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      ph <= 0;
    end else begin
      if (ldA)  n_lda <= n_lda + 1;
      if (sftA) n_sft <= n_sft + 1;
      if (decr) n_dec <= n_dec + 1;
      case (ph)
        0: if (bus.in_valid) begin
          ph <= 1; mdl_m <= bus.in_data; n_lda <= 0; n_sft <= 0; n_dec <= 0;
        end
        1: if (bus.in_valid) begin
          ph <= 2; mdl_q <= bus.in_data; left <= LAT;
        end
        2: begin
          left <= left - 1;
          if (left == 1) ph <= 3;
        end
        default: if (bus.out_ready) ph <= 0;
      endcase
    end
  end

  // Per-cycle compare, mid-cycle on the falling edge
  always @(negedge clk) begin
    logic [10:0] strb, exp_s;
    int k, i;
    logic cur, prv;
    strb = {ldA, ldQ, ldM, clrA, clrQ, clrff, sftA, sftQ, addsub, decr, ldCnt};
    chk("in_ready", 32'(bus.in_ready), 32'(ph <= 1));
    chk("busy", 32'(bus.busy), 32'(ph == 1 || ph == 2));
    chk("out_valid", 32'(bus.out_valid), 32'(ph == 3));
    chk("data_out", 32'(data_out), 32'(bus.in_data));
    if (!ldA) chk("addsub_gated", 32'(addsub), 32'(0));
    exp_s = '0;
    if (!rst) begin
      case (ph)
        0: exp_s = bus.in_valid ? S_BEAT1 : '0;
        1: exp_s = bus.in_valid ? S_BEAT2 : '0;
        2: begin
          k = int'(LAT) - left;
          if (k % 2 == 1) exp_s = S_SHIFT;
          else if (k < 2 * int'(W)) begin
            i = k / 2;
            cur = mdl_q[i];
            prv = (i == 0) ? 1'b0 : mdl_q[i-1];
            if ({cur, prv} == 2'b01) exp_s = S_ADD;
            else if ({cur, prv} == 2'b10) exp_s = S_SUB;
          end
        end
        default: exp_s = '0;
      endcase
    end
    chk("strobes", 32'(strb), 32'(exp_s));
    if (ph == 3 && !rst) begin
      chk("product", {dp_a[W-1:0], dp_q}, smul(mdl_m, mdl_q));
      if (!seen_done) begin
        chk("sft_count", 32'(n_sft), 32'(W));
        chk("decr_count", 32'(n_dec), 32'(W));
        chk("lda_count", 32'(n_lda), 32'(booth_ops(mdl_q)));
      end
      seen_done <= 1'b1;
    end else begin
      seen_done <= 1'b0;
    end
  end

  task automatic send_beat(input logic [W-1:0] d);
    bit ok = 1'b0;
    for (int t = 0; t < 60 && !ok; t++) begin
      @(negedge clk); #1;
      bus.in_valid = 1'b1;
      bus.in_data  = d;
      ok = bus.in_ready;
      @(posedge clk);
    end
    if (!ok) chk("beat_timeout", 32'(0), 32'(1));
  endtask

  task automatic run_op(input logic [W-1:0] m, input logic [W-1:0] q, input int gap,
                        input int hold, input bit lit, input logic [W-1:0] ea,
                        input logic [W-1:0] eq);
    int n = 0;
    bit done = 1'b0;
    bus.out_ready = 1'b0;
    send_beat(m);
    repeat (gap) begin
      @(negedge clk); #1;
      bus.in_valid = 1'b0;
      bus.in_data  = W'($urandom);
    end
    send_beat(q);
    // in_valid/out_ready toggle randomly while computing; both must be ignored
    do begin
      #1;
      done = bus.out_valid;
      bus.in_valid  = done ? 1'b0 : 1'($urandom_range(1, 0));
      bus.in_data   = W'($urandom);
      bus.out_ready = done ? (hold == 0) : 1'($urandom_range(1, 0));
      if (!done) begin
        @(posedge clk);
        n++;
      end
    end while (!done && n < 200);
    if (!done) chk("valid_timeout", 32'(0), 32'(1));
    chk("latency", 32'(n), 32'(LAT));
    if (lit) begin
      chk("lit_A", 32'(dp_a[W-1:0]), 32'(ea));
      chk("lit_Q", 32'(dp_q), 32'(eq));
    end
    if (hold > 0) begin
      repeat (hold) @(posedge clk);
      #1 chk("hold_valid", 32'(bus.out_valid), 32'(1));
      bus.out_ready = 1'b1;
    end
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    chk("released", 32'(bus.out_valid), 32'(0));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] corner [6];
    logic [W-1:0] rm, rq;
    corner[0] = 16'h8000; corner[1] = 16'h7FFF; corner[2] = 16'hFFFF;
    corner[3] = 16'h0000; corner[4] = 16'h0001; corner[5] = 16'h5555;
    bus.in_valid  = 1'b1;
    bus.in_data   = 16'h1111;
    bus.out_ready = 1'b0;
    // Reset with in_valid high: strobes must stay low while rst is asserted
    repeat (3) @(posedge clk);
    #1 chk("rst_strobes", 32'({ldM, clrA, ldCnt}), 32'(0));
    bus.in_valid = 1'b0;
    @(negedge clk); #1 rst = 1'b0;

    run_op(16'h0003, 16'h0005, 0, 0, 1'b1, 16'h0000, 16'h000F);
    run_op(16'hFFFD, 16'h0005, 0, 0, 1'b1, 16'hFFFF, 16'hFFF1);
    run_op(16'h7FFF, 16'h7FFF, 0, 0, 1'b1, 16'h3FFF, 16'h0001);
    run_op(16'h8000, 16'h8000, 0, 0, 1'b1, 16'h4000, 16'h0000);
    run_op(16'h1234, 16'h0000, 0, 0, 1'b1, 16'h0000, 16'h0000);
    chk("zero_lda", 32'(n_lda), 32'(0));
    chk("zero_sft", 32'(n_sft), 32'(16));
    chk("zero_decr", 32'(n_dec), 32'(16));
    run_op(16'h0007, 16'hFFF9, 4, 5, 1'b1, 16'hFFFF, 16'hFFCF);

    // Reset during the SHIFT of iteration 7
    send_beat(16'h0003);
    send_beat(16'h0055);
    #1 bus.in_valid = 1'b0;
    repeat (13) @(posedge clk);
    #2 chk("pre_rst_sftA", 32'(sftA), 32'(1));
    rst = 1'b1;
    #1 chk("rst_async_strobes", 32'({ldA, sftA, sftQ, decr, addsub}), 32'(0));
    chk("rst_in_ready", 32'(bus.in_ready), 32'(1));
    chk("rst_busy", 32'(bus.busy), 32'(0));
    @(posedge clk); #1 rst = 1'b0;
    run_op(16'h0003, 16'h0005, 0, 0, 1'b1, 16'h0000, 16'h000F);

    for (int r = 0; r < 24; r++) begin
      rm = ($urandom_range(3, 0) == 0) ? corner[$urandom_range(5, 0)] : W'($urandom);
      rq = ($urandom_range(3, 0) == 0) ? corner[$urandom_range(5, 0)] : W'($urandom);
      run_op(rm, rq, $urandom_range(3, 0), $urandom_range(3, 0), 1'b0, '0, '0);
    end

    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule
